seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, handshaked successor to the team's 8-bit clocked ALU. Performs the same 32-opcode operation set on `WIDTH`-bit operands with a valid/ready interface on input and output, a one-entry output register with backpressure, and an iterative multi-cycle divider. Flags are computed from the result being registered, not from the previous result. Sits between the operand-fetch stage and the writeback/flag register of the datapath.

## Interface
- `WIDTH`, 8: operand width in bits (≥4, power of two); result is `2*WIDTH` bits.
- `clk` in 1: clock, rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `in_valid` in 1: operand/opcode valid.
- `in_ready` out 1: block accepts when `in_valid && in_ready`.
- `a`, `b` in `WIDTH`: operands, unsigned unless stated.
- `opcode` in 5: operation select.
- `out_valid` out 1: result and flags valid.
- `out_ready` in 1: consumer takes the result when `out_valid && out_ready`.
- `result` out `2*WIDTH`: operation result.
- `carry`, `zero`, `overflow`, `negative`, `error` out 1 each: status flags qualified by `out_valid`.

## Operation
- **States**
  - IDLE: empty.
  - DIV: iterating.
  - OUT: holding the result.
- **Transitions**
  - IDLE→OUT on accepting a single-cycle op.
  - IDLE→DIV on accepting a divide with `b != 0`.
  - DIV→OUT after `WIDTH` iterations.
  - OUT→IDLE on `out_ready` with no new accept.
  - OUT→OUT or OUT→DIV on `out_ready` with a simultaneous accept.
- `in_ready` = (state==IDLE) || (state==OUT && out_ready). It is low throughout DIV.
- **Opcodes.** All results are zero-extended to `2*WIDTH` unless stated.
  - **Arithmetic**
    - 00000 add; 00001 sub.
    - 00010 mul: full `2*WIDTH` result.
    - 00011 div: result = {remainder, quotient}.
    - 00100 inc; 00101 dec; 00110 negate (two's complement, low `WIDTH` bits); 00111 abs (signed `a`).
  - **Logical:** 01000–01111 are AND, OR, XOR, NOT a, NAND, NOR, XNOR, a AND NOT b.
  - **Shift and rotate**
    - 10000 shl1; 10001 shr1 (logical); 10010 asr1.
    - 10011 rol1; 10100 ror1; 10101 rol2; 10110 ror2.
    - 10111 swap halves of `a`.
  - **Compare:** 11000–11011 are eq, ne, gt, lt (unsigned); result is 1 or 0.
  - **Bit ops:** 11100 set, 11101 clear, 11110 toggle bit `b` of `a`. If `b >= WIDTH`, result = `a` unchanged.
  - **Parity:** 11111 = XOR-reduction of `a`.
- **Flags.** All are written together with `result`.
  - `carry`: add carry-out; sub borrow (a<b); shl/shr/asr shifted-out bit. 0 otherwise.
  - `overflow`: signed overflow for add, sub, inc, dec, negate, abs (operand is the most-negative value). 0 otherwise.
  - `negative`: `result[WIDTH-1]`, except for mul and div, where it is `result[2*WIDTH-1]`.
  - `zero`: `result == 0` over all `2*WIDTH` bits.
  - `error`: divide by zero only. Result is then 0, `zero`=1, and the op completes as single-cycle without entering DIV.
- **Divider:** restoring, one quotient bit per cycle, MSB first. Operands are captured at accept and are not re-sampled.

## Timing
- Reset values:
  - state IDLE.
  - `out_valid`=0, `result`=0.
  - `carry`=`overflow`=`negative`=`error`=0, `zero`=1.
- `in_ready`=1 in the first cycle after reset deasserts.
- Single-cycle op accepted at edge N: `out_valid`=1 after edge N+1, i.e. visible in cycle N+1.
- Divide accepted at edge N: `out_valid` visible in cycle N+WIDTH+1.
- `result` and flags are stable while `out_valid && !out_ready`.
- With `out_ready` held high, throughput is one single-cycle op per cycle.
- Reset during DIV or OUT abandons the operation: outputs return to reset values on that edge, and no result is delivered.
- `opcode`, `a`, `b` are ignored when no accept occurs.

## Configuration
- `SEQ_ALU_DIV_EN` defined: divider sub-module instantiated; opcode 00011 behaves as above.
- Not defined: no divider logic and DIV state absent. Opcode 00011 completes single-cycle with `result`=0, `error`=1, `zero`=1.

## Structure
- Shared package `seq_alu_pkg`:
  - opcode enum (32 named values);
  - state enum {IDLE, DIV, OUT};
  - flag struct {carry, zero, overflow, negative, error}.
- Sub-module `seq_alu_div`: parameter `WIDTH`, with start, done, quotient, and remainder.
- Top module: FSM, combinational single-cycle datapath, output register.

## Test plan
- WIDTH=8, add 0xFF+0x01 → result 0x0000, carry=1, zero=1, overflow=0. Then 0x7F+0x01 → 0x0080, overflow=1, negative=1.
- Div 200/7 → result 0x041C (rem 4, quo 28). `out_valid` 9 cycles after accept; `in_ready`=0 for the 8 DIV cycles.
- Div 5/0 → result 0, error=1, zero=1, `out_valid` next cycle. Then mul 0xFF*0xFF → 0xFE01, error=0.
- `out_ready`=0 for 3 cycles after a sub 0x03-0x05 → result 0x00FE, carry=1, held stable, `in_ready`=0. Then `out_ready`=1 with new `in_valid` → back-to-back accept, no bubble.
- Reset asserted 3 cycles into a divide → next cycle `out_valid`=0, zero=1, `in_ready`=1. A following inc 0x41 → 0x0042.
- Bit ops: set bit 9 of 0x10 (WIDTH=8) → 0x0010; toggle bit 4 of 0x10 → 0x0000, zero=1. Build without `SEQ_ALU_DIV_EN`: div 9/3 → error=1, 1-cycle latency.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcode set, control states and the status flag bundle.
package seq_alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_MUL  = 5'd2,  OP_DIV  = 5'd3,
    OP_INC  = 5'd4,  OP_DEC  = 5'd5,  OP_NEG  = 5'd6,  OP_ABS  = 5'd7,
    OP_AND  = 5'd8,  OP_OR   = 5'd9,  OP_XOR  = 5'd10, OP_NOT  = 5'd11,
    OP_NAND = 5'd12, OP_NOR  = 5'd13, OP_XNOR = 5'd14, OP_ANDN = 5'd15,
    OP_SHL  = 5'd16, OP_SHR  = 5'd17, OP_ASR  = 5'd18, OP_ROL1 = 5'd19,
    OP_ROR1 = 5'd20, OP_ROL2 = 5'd21, OP_ROR2 = 5'd22, OP_SWAP = 5'd23,
    OP_EQ   = 5'd24, OP_NE   = 5'd25, OP_GT   = 5'd26, OP_LT   = 5'd27,
    OP_SET  = 5'd28, OP_CLR  = 5'd29, OP_TGL  = 5'd30, OP_PAR  = 5'd31
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    OUT  = 2'd2
  } state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic overflow;
    logic negative;
    logic error;
  } flags_t;

  localparam flags_t FLAGS_RST = '{carry: 1'b0, zero: 1'b1, overflow: 1'b0,
                                   negative: 1'b0, error: 1'b0};

endpackage

// File: rtl/seq_alu_div.sv
// Restoring divider, one quotient bit per cycle MSB first; the first step runs on the start edge.
module seq_alu_div
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] rem_d, quo_d;
  logic [WIDTH-1:0] rem_src, quo_src, dvs_src;
  logic [WIDTH:0]   trial;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;

  // quo holds the not-yet-consumed dividend bits on the left and quotient bits shifting in on the right
  always_comb begin
    rem_src = start_i ? '0  : rem_q;
    quo_src = start_i ? a_i : quo_q;
    dvs_src = start_i ? b_i : dvs_q;
    trial   = {rem_src, quo_src[WIDTH-1]} - {1'b0, dvs_src};
    if (trial[WIDTH]) begin
      rem_d = {rem_src[WIDTH-2:0], quo_src[WIDTH-1]};
      quo_d = {quo_src[WIDTH-2:0], 1'b0};
    end else begin
      rem_d = trial[WIDTH-1:0];
      quo_d = {quo_src[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= CW'(1);
    end else if (busy_q) begin
      if (cnt_q == LAST) busy_q <= 1'b0;
      else               cnt_q  <= cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (start_i || (busy_q && (cnt_q != LAST))) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_src;
    end
  end

  assign done_o      = busy_q && (cnt_q == LAST);
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/seq_alu.sv
// Handshaked 32-op ALU with one-entry output register; the iterative divider is built only
// when SEQ_ALU_DIV_EN is defined, otherwise divide reports error in a single cycle.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [4:0]         opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               zero,
  output logic               overflow,
  output logic               negative,
  output logic               error
);

  localparam int MSB  = WIDTH - 1;
  localparam int IDXW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] W_VAL   = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS = ~MIN_NEG;

  state_e               state_q;
  logic [2*WIDTH-1:0]   result_q;
  flags_t               flags_q;

  opcode_e              op;
  logic signed [WIDTH-1:0] a_s;
  logic [2*WIDTH-1:0]   res_d;
  logic [WIDTH-1:0]     lo_d, mask_d;
  logic [WIDTH:0]       ext_d;
  logic                 wide_d, in_rng_d;
  flags_t               flg_d;
  logic                 accept, div_start;

  assign op       = opcode_e'(opcode);
  assign a_s      = a;
  assign mask_d   = ONE << b[IDXW-1:0];
  assign in_rng_d = (b < W_VAL);
  assign accept   = in_valid && in_ready;

  always_comb begin
    lo_d   = '0;
    ext_d  = '0;
    res_d  = '0;
    flg_d  = '0;
    wide_d = 1'b0;
    case (op)
      OP_ADD: begin
        ext_d          = {1'b0, a} + {1'b0, b};
        lo_d           = ext_d[WIDTH-1:0];
        flg_d.carry    = ext_d[WIDTH];
        flg_d.overflow = (a[MSB] == b[MSB]) && (lo_d[MSB] != a[MSB]);
      end
      OP_SUB: begin
        ext_d          = {1'b0, a} - {1'b0, b};
        lo_d           = ext_d[WIDTH-1:0];
        flg_d.carry    = ext_d[WIDTH];
        flg_d.overflow = (a[MSB] != b[MSB]) && (lo_d[MSB] != a[MSB]);
      end
      OP_MUL: begin
        wide_d = 1'b1;
        res_d  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      end
      // Only reached for a zero divisor or a build without the divider.
      OP_DIV: begin
        wide_d      = 1'b1;
        flg_d.error = 1'b1;
      end
      OP_INC:  begin lo_d = a + ONE; flg_d.overflow = (a == MAX_POS); end
      OP_DEC:  begin lo_d = a - ONE; flg_d.overflow = (a == MIN_NEG); end
      OP_NEG:  begin lo_d = -a_s;    flg_d.overflow = (a == MIN_NEG); end
      OP_ABS:  begin lo_d = a_s[MSB] ? -a_s : a_s; flg_d.overflow = (a == MIN_NEG); end
      OP_AND:  lo_d = a & b;
      OP_OR:   lo_d = a | b;
      OP_XOR:  lo_d = a ^ b;
      OP_NOT:  lo_d = ~a;
      OP_NAND: lo_d = ~(a & b);
      OP_NOR:  lo_d = ~(a | b);
      OP_XNOR: lo_d = ~(a ^ b);
      OP_ANDN: lo_d = a & ~b;
      OP_SHL:  begin lo_d = {a[MSB-1:0], 1'b0}; flg_d.carry = a[MSB]; end
      OP_SHR:  begin lo_d = {1'b0, a[MSB:1]};   flg_d.carry = a[0];   end
      OP_ASR:  begin lo_d = a_s >>> 1;          flg_d.carry = a[0];   end
      OP_ROL1: lo_d = {a[MSB-1:0], a[MSB]};
      OP_ROR1: lo_d = {a[0], a[MSB:1]};
      OP_ROL2: lo_d = {a[MSB-2:0], a[MSB:MSB-1]};
      OP_ROR2: lo_d = {a[1:0], a[MSB:2]};
      OP_SWAP: lo_d = {a[WIDTH/2-1:0], a[MSB:WIDTH/2]};
      OP_EQ:   lo_d = {{(WIDTH-1){1'b0}}, a == b};
      OP_NE:   lo_d = {{(WIDTH-1){1'b0}}, a != b};
      OP_GT:   lo_d = {{(WIDTH-1){1'b0}}, a > b};
      OP_LT:   lo_d = {{(WIDTH-1){1'b0}}, a < b};
      OP_SET:  lo_d = in_rng_d ? (a | mask_d)  : a;
      OP_CLR:  lo_d = in_rng_d ? (a & ~mask_d) : a;
      OP_TGL:  lo_d = in_rng_d ? (a ^ mask_d)  : a;
      OP_PAR:  lo_d = {{(WIDTH-1){1'b0}}, ^a};
      default: lo_d = '0;
    endcase
    if (!wide_d) res_d = {{WIDTH{1'b0}}, lo_d};
    flg_d.zero     = (res_d == '0);
    flg_d.negative = wide_d ? res_d[2*WIDTH-1] : res_d[MSB];
  end

`ifdef SEQ_ALU_DIV_EN
  logic             div_done;
  logic [WIDTH-1:0] div_quo, div_rem;
  flags_t           div_flg;

  assign div_start = accept && (op == OP_DIV) && (b != '0);

  seq_alu_div #(.WIDTH(WIDTH)) u_div (
    .clk         (clk),
    .reset       (reset),
    .start_i     (div_start),
    .a_i         (a),
    .b_i         (b),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  always_comb begin
    div_flg          = '0;
    div_flg.zero     = ({div_rem, div_quo} == '0);
    div_flg.negative = div_rem[MSB];
  end
`else
  assign div_start = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= FLAGS_RST;
    end else begin
`ifdef SEQ_ALU_DIV_EN
      if (state_q == DIV) begin
        if (div_done) begin
          state_q  <= OUT;
          result_q <= {div_rem, div_quo};
          flags_q  <= div_flg;
        end
      end else
`endif
      if (accept) begin
        if (div_start) begin
          state_q <= DIV;
        end else begin
          state_q  <= OUT;
          result_q <= res_d;
          flags_q  <= flg_d;
        end
      end else if ((state_q == OUT) && out_ready) begin
        state_q <= IDLE;
      end
    end
  end

  assign in_ready  = (state_q == IDLE) || ((state_q == OUT) && out_ready);
  assign out_valid = (state_q == OUT);
  assign result    = result_q;
  assign carry     = flags_q.carry;
  assign zero      = flags_q.zero;
  assign overflow  = flags_q.overflow;
  assign negative  = flags_q.negative;
  assign error     = flags_q.error;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed literal cases plus randomized traffic against an arithmetic reference model.
module tb_seq_alu;

  localparam int W = 8;
  localparam int M = 1 << W;
`ifdef SEQ_ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset, in_valid, in_ready, out_valid, out_ready;
  logic           carry, zero, overflow, negative, error;
  logic [W-1:0]   a, b;
  logic [4:0]     opcode;
  logic [2*W-1:0] result;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero), .overflow(overflow),
    .negative(negative), .error(error)
  );

  typedef struct {
    logic [2*W-1:0] res;
    logic [4:0]     flg;   // {carry, zero, overflow, negative, error}
    int             lat;
    int             vis;
  } exp_t;

  exp_t q[$];
  bit   chk_en = 1'b0;
  int   cyc = 0;
  logic exp_v, exp_rdy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    int ai, bi, sa, sb, r, t, h;
    logic c, o, er, wide;
    ai = int'(av); bi = int'(bv);
    sa = (ai >= M/2) ? ai - M : ai;
    sb = (bi >= M/2) ? bi - M : bi;
    c = 0; o = 0; er = 0; wide = 0; r = 0; e.lat = 1; e.vis = 0;
    h = 1 << (W/2);
    case (int'(op))
      0:  begin t = ai + bi; r = t % M; c = (t >= M); o = (sa+sb > M/2-1) || (sa+sb < -M/2); end
      1:  begin r = (ai - bi + M) % M; c = (ai < bi); o = (sa-sb > M/2-1) || (sa-sb < -M/2); end
      2:  begin r = ai * bi; wide = 1; end
      3:  begin
            wide = 1;
            if (bi == 0 || !DIV_EN) er = 1;
            else begin r = (ai % bi) * M + ai / bi; e.lat = W + 1; end
          end
      4:  begin r = (ai + 1) % M;     o = (sa == M/2 - 1); end
      5:  begin r = (ai + M - 1) % M; o = (sa == -M/2); end
      6:  begin r = (M - ai) % M;     o = (sa == -M/2); end
      7:  begin r = (sa < 0) ? (M - ai) % M : ai; o = (sa == -M/2); end
      8:  r = ai & bi;
      9:  r = ai | bi;
      10: r = ai ^ bi;
      11: r = (M-1) - ai;
      12: r = (M-1) - (ai & bi);
      13: r = (M-1) - (ai | bi);
      14: r = (M-1) - (ai ^ bi);
      15: r = ai & ((M-1) - bi);
      16: begin r = (ai * 2) % M; c = (ai >= M/2); end
      17: begin r = ai / 2; c = ai % 2; end
      18: begin r = ((sa - ai % 2) / 2 + M) % M; c = ai % 2; end
      19: r = (ai * 2) % M + ai / (M/2);
      20: r = ai / 2 + (ai % 2) * (M/2);
      21: r = (ai * 4) % M + ai / (M/4);
      22: r = ai / 4 + (ai % 4) * (M/4);
      23: r = (ai % h) * h + ai / h;
      24: r = (ai == bi);
      25: r = (ai != bi);
      26: r = (ai > bi);
      27: r = (ai < bi);
      28: r = (bi < W) ? (ai | (1 << bi)) : ai;
      29: r = (bi < W) ? (ai & ((M-1) - (1 << bi))) : ai;
      30: r = (bi < W) ? (ai ^ (1 << bi)) : ai;
      default: r = $countones(av) % 2;
    endcase
    e.res = r[2*W-1:0];
    e.flg = {c, (r == 0), o, (wide ? e.res[2*W-1] : e.res[W-1]), er};
    return e;
  endfunction

  // Per-cycle scoreboard: checks handshake and output against the queued model results.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_v   = (q.size() > 0) && (cyc >= q[0].vis);
      exp_rdy = (q.size() == 0) || (exp_v && out_ready);
      chk("out_valid", out_valid, exp_v);
      chk("in_ready", in_ready, exp_rdy);
      if (exp_v) begin
        chk("result", result, q[0].res);
        chk("flags", {carry, zero, overflow, negative, error}, q[0].flg);
      end
      if (reset) begin
        q.delete();
      end else begin
        if (exp_v && out_ready) void'(q.pop_front());
        if (in_valid && exp_rdy) begin
          exp_t e;
          e = model(opcode, a, b);
          e.vis = cyc + e.lat;
          q.push_back(e);
        end
      end
    end
    cyc++;
  end

  task automatic drive(input logic v, input logic [4:0] op, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic rdy);
    @(posedge clk); #1;
    in_valid = v; opcode = op; a = av; b = bv; out_ready = rdy;
  endtask

  task automatic wait_accept(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) chk({nm, " accept timeout"}, 0, 1);
  endtask

  task automatic dir_op(input string nm, input logic [4:0] op, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [2*W-1:0] er,
                        input logic [4:0] ef, input int elat);
    int lat, low;
    drive(1'b1, op, av, bv, 1'b1);
    wait_accept(nm);
    drive(1'b0, op, av, bv, 1'b1);
    lat = 0; low = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!in_ready) low++;
    end while (!out_valid && lat < 40);
    chk({nm, " latency"}, lat, elat);
    chk({nm, " busy cycles"}, low, elat - 1);
    chk({nm, " result"}, result, er);
    chk({nm, " flags"}, {carry, zero, overflow, negative, error}, ef);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1);
  end

  initial begin
    exp_t m;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; opcode = '0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset result", result, 0);
    chk("reset flags", {carry, zero, overflow, negative, error}, 5'b01000);
    chk("reset in_ready", in_ready, 1);

    // Pin the reference model against hand-computed values.
    m = model(5'd1, 8'h03, 8'h05); chk("model sub", {m.res, 3'b0, m.flg}, {16'h00FE, 3'b0, 5'b10010});
    m = model(5'd21, 8'h81, 8'h00); chk("model rol2", m.res, 16'h0006);
    m = model(5'd23, 8'hA5, 8'h00); chk("model swap", m.res, 16'h005A);
    m = model(5'd18, 8'h81, 8'h00); chk("model asr", {m.res, 3'b0, m.flg}, {16'h00C0, 3'b0, 5'b10010});

    @(posedge clk); #1 reset = 1'b0;

    dir_op("add ff+1", 5'd0, 8'hFF, 8'h01, 16'h0000, 5'b11000, 1);
    dir_op("add 7f+1", 5'd0, 8'h7F, 8'h01, 16'h0080, 5'b00110, 1);
`ifdef SEQ_ALU_DIV_EN
    dir_op("div 200/7", 5'd3, 8'd200, 8'd7, 16'h041C, 5'b00000, W + 1);
    dir_op("div 5/0", 5'd3, 8'd5, 8'd0, 16'h0000, 5'b01001, 1);
`else
    dir_op("div 9/3", 5'd3, 8'd9, 8'd3, 16'h0000, 5'b01001, 1);
`endif
    dir_op("mul ff*ff", 5'd2, 8'hFF, 8'hFF, 16'hFE01, 5'b00010, 1);
    dir_op("set bit9", 5'd28, 8'h10, 8'd9, 16'h0010, 5'b00000, 1);
    dir_op("tgl bit4", 5'd30, 8'h10, 8'd4, 16'h0000, 5'b01000, 1);

    // Backpressure: result held while the consumer stalls, then back-to-back accept.
    drive(1'b1, 5'd1, 8'h03, 8'h05, 1'b0);
    wait_accept("bp sub");
    drive(1'b0, 5'd1, 8'h03, 8'h05, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp hold valid", out_valid, 1);
      chk("bp hold result", result, 16'h00FE);
      chk("bp hold carry", carry, 1);
      chk("bp in_ready", in_ready, 0);
    end
    drive(1'b1, 5'd0, 8'h01, 8'h02, 1'b1);
    @(negedge clk);
    chk("bp simultaneous accept", in_ready, 1);
    drive(1'b0, 5'd0, 8'h01, 8'h02, 1'b1);
    @(negedge clk);
    chk("bp no bubble valid", out_valid, 1);
    chk("bp no bubble result", result, 16'h0003);

`ifdef SEQ_ALU_DIV_EN
    drive(1'b1, 5'd3, 8'd200, 8'd7, 1'b1);
    wait_accept("rst div");
    drive(1'b0, 5'd3, 8'd200, 8'd7, 1'b1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst div out_valid", out_valid, 0);
    chk("rst div zero", zero, 1);
    chk("rst div in_ready", in_ready, 1);
`endif
    drive(1'b1, 5'd0, 8'h01, 8'h01, 1'b0);
    wait_accept("rst out");
    drive(1'b0, 5'd0, 8'h01, 8'h01, 1'b0);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("rst out out_valid", out_valid, 0);
    chk("rst out result", result, 0);
    chk("rst out zero", zero, 1);
    dir_op("inc 41", 5'd4, 8'h41, 8'h00, 16'h0042, 5'b00000, 1);

    // Randomized traffic with random backpressure and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      reset     = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      opcode    = 5'($urandom);
      a         = 8'($urandom);
      b         = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (W + 4) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
